nco_sweep_ctrl: RTL

- Sequences an NCO (32-bit phase increment in, 14-bit signed sine out, clken/out_valid) through a stepped frequency sweep.
- For each step: loads the phase increment, discards the NCO pipeline-settling samples, then forwards a fixed number of samples downstream over a valid/ready interface.
- Applies backpressure to the NCO via clken.
- Sits between the acquisition control registers and the NCO/sample FIFO.

---
 rtl/nco_ctrl_pkg.sv | 19 +
 rtl/nco_sweep_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/nco_ctrl_pkg.sv
// Shared types and default widths for the NCO stepped-frequency sweep controller.
package nco_ctrl_pkg;

    localparam int unsigned PHI_W_DEF   = 32;
    localparam int unsigned OUT_W_DEF   = 14;
    localparam int unsigned STEP_W_DEF  = 8;
    localparam int unsigned DWELL_W_DEF = 16;
    localparam int unsigned SETTLE_DEF  = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_DWELL,
        S_DRAIN,
        S_DONE
    } state_e;

endpackage

// File: rtl/nco_sweep_ctrl.sv
// Steps an NCO through a frequency sweep, discarding settling samples and forwarding a dwell per step.
// Optional macro NCO_STEP_TAG_EN adds s_step (step index per sample) and step_start (LOAD-cycle pulse).
module nco_sweep_ctrl
    import nco_ctrl_pkg::*;
#(
    parameter int unsigned PHI_W   = PHI_W_DEF,
    parameter int unsigned OUT_W   = OUT_W_DEF,
    parameter int unsigned STEP_W  = STEP_W_DEF,
    parameter int unsigned DWELL_W = DWELL_W_DEF,
    parameter int unsigned SETTLE  = SETTLE_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [PHI_W-1:0]   cfg_phi_start,
    input  logic [PHI_W-1:0]   cfg_phi_step,
    input  logic [STEP_W-1:0]  cfg_num_steps,
    input  logic [DWELL_W-1:0] cfg_dwell,
    output logic               busy,
    output logic               done,
    output logic [PHI_W-1:0]   nco_phi_inc,
    output logic               nco_clken,
    input  logic               nco_valid,
    input  logic [OUT_W-1:0]   nco_sin,
    output logic               s_valid,
    output logic [OUT_W-1:0]   s_data,
    output logic               s_last,
`ifdef NCO_STEP_TAG_EN
    output logic [STEP_W-1:0]  s_step,
    output logic               step_start,
`endif
    input  logic               s_ready
);

    // SETTLE must be at least 1; the counter holds 0..SETTLE-1.
    localparam int unsigned SET_W = $clog2(SETTLE + 1);

    state_e               state_q;
    state_e               state_d;

    logic [PHI_W-1:0]     phi_cur_q;
    logic [PHI_W-1:0]     phi_step_q;
    logic [STEP_W-1:0]    num_steps_q;
    logic [STEP_W-1:0]    step_idx_q;
    logic [DWELL_W-1:0]   dwell_q;
    logic [DWELL_W-1:0]   dwell_cnt_q;
    logic [SET_W-1:0]     settle_cnt_q;

    logic                 clken;
    logic                 produce;
    logic                 xfer;
    logic                 settle_last;
    logic                 dwell_last;
    logic                 final_step;
    logic                 load_sample;
    logic                 accept;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus the combinational handshake strobes shared with the datapath.
    always_comb begin
        state_d     = state_q;
        clken       = 1'b0;
        produce     = 1'b0;
        xfer        = s_valid & s_ready;
        settle_last = (settle_cnt_q == SET_W'(SETTLE - 1));
        dwell_last  = (dwell_cnt_q == (dwell_q - DWELL_W'(1)));
        final_step  = (step_idx_q == (num_steps_q - STEP_W'(1)));
        load_sample = 1'b0;
        accept      = 1'b0;

        if ((state_q == S_SETTLE) || (state_q == S_DWELL)) begin
            clken = ~s_valid | s_ready;
        end
        produce     = clken & nco_valid;
        load_sample = produce & (state_q == S_DWELL);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = (cfg_num_steps == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (produce && settle_last) begin
                    state_d = S_DWELL;
                end
            end
            S_DWELL: begin
                if (produce && dwell_last) begin
                    state_d = final_step ? S_DRAIN : S_LOAD;
                end
            end
            S_DRAIN: begin
                if (xfer && s_last) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign nco_clken = clken;

    // Configuration, sweep counters and phase bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy         <= 1'b0;
            done         <= 1'b0;
            nco_phi_inc  <= '0;
            phi_cur_q    <= '0;
            phi_step_q   <= '0;
            num_steps_q  <= '0;
            step_idx_q   <= '0;
            dwell_q      <= '0;
            dwell_cnt_q  <= '0;
            settle_cnt_q <= '0;
        end else begin
            done <= (state_q == S_DONE);

            if (accept) begin
                busy        <= 1'b1;
                phi_cur_q   <= cfg_phi_start;
                phi_step_q  <= cfg_phi_step;
                num_steps_q <= cfg_num_steps;
                step_idx_q  <= '0;
                dwell_q     <= (cfg_dwell == '0) ? DWELL_W'(1) : cfg_dwell;
            end

            if (state_q == S_DONE) begin
                busy <= 1'b0;
            end

            if (state_q == S_LOAD) begin
                nco_phi_inc  <= phi_cur_q;
                settle_cnt_q <= '0;
            end

            if ((state_q == S_SETTLE) && produce) begin
                if (settle_last) begin
                    dwell_cnt_q <= '0;
                end else begin
                    settle_cnt_q <= settle_cnt_q + SET_W'(1);
                end
            end

            if ((state_q == S_DWELL) && produce) begin
                if (dwell_last) begin
                    if (!final_step) begin
                        phi_cur_q  <= phi_cur_q + phi_step_q;
                        step_idx_q <= step_idx_q + STEP_W'(1);
                    end
                end else begin
                    dwell_cnt_q <= dwell_cnt_q + DWELL_W'(1);
                end
            end
        end
    end

    // Output holding register; clken gating guarantees a load never overwrites a pending sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            s_valid <= 1'b0;
            s_data  <= '0;
            s_last  <= 1'b0;
        end else if (load_sample) begin
            s_valid <= 1'b1;
            s_data  <= nco_sin;
            s_last  <= dwell_last & final_step;
        end else if (xfer || (state_q == S_DONE)) begin
            s_valid <= 1'b0;
            s_last  <= 1'b0;
        end
    end

`ifdef NCO_STEP_TAG_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            s_step <= '0;
        end else if (load_sample) begin
            s_step <= step_idx_q;
        end
    end

    assign step_start = (state_q == S_LOAD);
`endif

endmodule
